ysyx_22041207_lsu: RTL and testbench
====================================

// Module: ysyx_22041207_lsu
// PURPOSE
//  Parametrised load/store unit between the EXU/MEM stage and the AXI-lite data port.
//  Takes one load or store request at a time and aligns data and byte strobes for every legal
//  byte offset within a bus beat. Sign- or zero-extends load data and reports misaligned or
//  bus errors. busy stalls the pipeline while a transaction is outstanding.
// PARAMETERS
//  AW  64  address width in bits
//  DW  64  bus data width in bits, 32 or 64; beat bytes NB=DW/8, offset bits OW=log2(NB)
// PORTS
//  clk        in   1      clock; all state changes on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  req_valid  in   1      request present; sampled only while req_ready=1
//  req_ready  out  1      unit idle and able to accept (state==IDLE)
//  req_wr     in   1      1=store, 0=load
//  req_addr   in   AW     byte address
//  req_size   in   2      log2(bytes): 0=1B 1=2B 2=4B 3=8B
//  req_sext   in   1      load: 1=sign-extend, 0=zero-extend
//  req_wdata  in   DW     store data, LSB-aligned
//  busy       out  1      state!=IDLE; pipeline stall
//  rsp_valid  out  1      one-cycle completion pulse
//  rsp_rdata  out  DW     extended load result; held until the next load completes
//  rsp_err    out  1      valid with rsp_valid: misaligned/oversize request or bus error
//  aw_valid   out  1      write address+data valid (combined AW/W channel)
//  aw_ready   in   1
//  aw_addr    out  AW     req_addr with low OW bits cleared
//  w_data     out  DW     req_wdata << 8*offset
//  w_strb     out  NB     ((1<<bytes)-1) << offset
//  b_valid    in   1      write response
//  b_ready    out  1
//  b_err      in   1      write response error, sampled with b_valid&&b_ready
//  ar_valid   out  1      read address valid
//  ar_ready   in   1
//  ar_addr    out  AW     req_addr with low OW bits cleared
//  ar_size    out  3      req_size
//  r_valid    in   1      read data valid
//  r_ready    out  1
//  r_data     in   DW     full read beat
//  r_err      in   1      read error, sampled with r_valid&&r_ready
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except req_ready=1; latched address, data, strobe and size=0.
//  Definitions: offset=req_addr[OW-1:0], bytes=1<<req_size.
//  Illegal request: req_addr % bytes != 0, or bytes > NB. These issue no bus traffic.
//  FSM: IDLE, W_ADDR, W_RESP, R_ADDR, R_DATA, ERR.
//  IDLE: accept on req_valid. Illegal request -> ERR. Legal store -> W_ADDR with aw_valid=1.
//    Legal load -> R_ADDR with ar_valid=1. Address, strobe, data, size and sext are latched at accept.
//  W_ADDR: hold aw_valid and its fields stable until aw_ready. On the handshake:
//    aw_valid<=0, b_ready<=1, next state W_RESP.
//  W_RESP: on b_valid&&b_ready: b_ready<=0, rsp_valid<=1, rsp_err<=b_err, next state IDLE.
//  R_ADDR: hold ar_valid stable until ar_ready. On the handshake: ar_valid<=0, r_ready<=1,
//    next state R_DATA.
//  R_DATA: on r_valid&&r_ready: r_ready<=0, rsp_valid<=1, rsp_err<=r_err, next state IDLE.
//    The result is x=r_data>>(8*offset), truncated to 8*bytes bits, then extended to DW per sext.
//    On r_err, rsp_rdata<=0.
//  ERR: rsp_valid<=1, rsp_err<=1, next state IDLE. rsp_rdata is unchanged.
//  rsp_valid is high for exactly one cycle, in the first IDLE cycle. A new request may be accepted
//    in that same cycle. Stores and ERR never modify rsp_rdata.
//  Minimum latency, accept edge to rsp_valid: 3 cycles when aw_ready/ar_ready and b_valid/r_valid
//    arrive at the earliest point. Illegal request: 2 cycles.
//  A response (b_valid/r_valid) arriving before its ready is asserted stays pending at the slave.
//    No response is lost or double-counted.
//  Reset mid-transaction: all state and outputs return to reset values asynchronously. The
//    outstanding bus transaction is abandoned, so the interconnect must share rst_n.
// TESTING
//  1. DW=64, store size=1, addr=0x8000_0006, wdata=0xBEEF -> aw_addr=0x8000_0000, w_strb=0xC0,
//     w_data=0xBEEF<<48; rsp_valid 1 cycle, rsp_err=0.
//  2. Load size=0, sext=1, addr=0x...03, r_data=0x0000_0000_8000_0000 -> rsp_rdata=0xFFFF_FFFF_FFFF_FF80.
//     Same load with sext=0 -> 0x80.
//  3. Load size=2, addr=0x...06 -> no ar_valid; rsp_valid+rsp_err exactly 2 cycles after accept.
//  4. Back-to-back: aw_ready/b_valid delayed 5 cycles. busy stays high throughout, aw_fields stable.
//     A load is accepted in the rsp_valid cycle and completes with the correct data.
//  5. r_err=1 on a size=3 load -> rsp_err=1, rsp_rdata=0. DW=32 instance with size=3 -> error, no bus traffic.
//  6. rst_n low during R_DATA -> all outputs reset immediately. After release, a fresh load completes normally.

Source files
------------

// File: rtl/ysyx_22041207_lsu.sv
// ----------------------------------------------------------------------------
// ysyx_22041207_lsu
//
// Load/store unit sitting between the EXU/MEM stage and an AXI-lite style data
// port. One request is in flight at a time. Store data and byte strobes are
// aligned to the bus beat. Load data is extracted from the beat and then sign-
// or zero-extended. Misaligned or oversize requests never reach the bus and
// are answered with an error. Bus errors are passed through on rsp_err.
//
// Parameters
//   AW  address width in bits
//   DW  bus data width in bits (32 or 64); NB = DW/8 bytes per beat
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (req_ready == idle)
//   req_wr, req_addr, req_size request type, byte address, log2(bytes)
//   req_sext, req_wdata        load extension mode, LSB-aligned store data
//   busy                       transaction outstanding (pipeline stall)
//   rsp_valid, rsp_err         one-cycle completion pulse and its status
//   rsp_rdata                  extended load result, held until next load
//   aw_valid/aw_ready, aw_addr, w_data, w_strb   combined write addr+data
//   b_valid/b_ready, b_err     write response
//   ar_valid/ar_ready, ar_addr, ar_size          read address
//   r_valid/r_ready, r_data, r_err               read data
// ----------------------------------------------------------------------------
module ysyx_22041207_lsu #(
   parameter int AW = 64,
   parameter int DW = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_wr,
   input  logic [AW-1:0]   req_addr,
   input  logic [1:0]      req_size,
   input  logic            req_sext,
   input  logic [DW-1:0]   req_wdata,
   output logic            busy,
   output logic            rsp_valid,
   output logic [DW-1:0]   rsp_rdata,
   output logic            rsp_err,
   output logic            aw_valid,
   input  logic            aw_ready,
   output logic [AW-1:0]   aw_addr,
   output logic [DW-1:0]   w_data,
   output logic [DW/8-1:0] w_strb,
   input  logic            b_valid,
   output logic            b_ready,
   input  logic            b_err,
   output logic            ar_valid,
   input  logic            ar_ready,
   output logic [AW-1:0]   ar_addr,
   output logic [2:0]      ar_size,
   input  logic            r_valid,
   output logic            r_ready,
   input  logic [DW-1:0]   r_data,
   input  logic            r_err
);

   localparam int NB = DW / 8;
   localparam int OW = $clog2(NB);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_W_ADDR = 3'd1,
      S_W_RESP = 3'd2,
      S_R_ADDR = 3'd3,
      S_R_DATA = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   // ------------------------------------------------------------------------
   // Registered state and outputs
   // ------------------------------------------------------------------------
   state_t        state_q,     state_d;
   logic          aw_valid_q,  aw_valid_d;
   logic          b_ready_q,   b_ready_d;
   logic          ar_valid_q,  ar_valid_d;
   logic          r_ready_q,   r_ready_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_err_q,   rsp_err_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [AW-1:0] addr_q,      addr_d;
   logic [DW-1:0] wdata_q,     wdata_d;
   logic [NB-1:0] strb_q,      strb_d;
   logic [1:0]    size_q,      size_d;
   logic          sext_q,      sext_d;
   logic [OW-1:0] off_q,       off_d;

   // ------------------------------------------------------------------------
   // Request decode (evaluated on the raw request inputs, used at accept)
   // ------------------------------------------------------------------------
   logic [OW-1:0] req_off;
   logic [2:0]    align_mask;
   logic          req_misalign;
   logic          req_oversize;
   logic          req_illegal;
   logic [AW-1:0] req_base;
   logic [4:0]    req_bytes;
   logic [NB-1:0] req_strb;
   logic [DW-1:0] req_wshift;

   assign req_off = req_addr[OW-1:0];

   // Low address bits that must be zero for a naturally aligned access.
   always_comb begin
      case (req_size)
         2'd0:    align_mask = 3'b000;
         2'd1:    align_mask = 3'b001;
         2'd2:    align_mask = 3'b011;
         default: align_mask = 3'b111;
      endcase
   end

   assign req_misalign = |(req_addr[2:0] & align_mask);
   assign req_oversize = (int'(req_size) > OW);
   assign req_illegal  = req_misalign | req_oversize;
   assign req_base     = {req_addr[AW-1:OW], {OW{1'b0}}};
   assign req_bytes    = 5'd1 << req_size;
   assign req_wshift   = req_wdata << {req_off, 3'b000};

   // Byte lane gi is written when offset <= gi < offset + bytes.
   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_strb
         assign req_strb[gi] = (5'(gi) >= 5'(req_off)) &&
                               (5'(gi) <  5'(req_off) + req_bytes);
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Load data path: shift the beat down by the latched offset, keep the low
   // 8*bytes bits and fill the rest with the sign bit or zero.
   // ------------------------------------------------------------------------
   logic [DW-1:0] rd_shift;
   logic [DW-1:0] rd_ext;
   logic [3:0]    rd_bytes;
   logic          rd_msb;
   logic          rd_fill;

   assign rd_shift = r_data >> {off_q, 3'b000};
   assign rd_bytes = 4'd1 << size_q;

   // Size 3 only reaches the data phase when the beat is 64 bits wide, so the
   // default arm always picks the true sign bit of a legal access.
   always_comb begin
      case (size_q)
         2'd0:    rd_msb = rd_shift[7];
         2'd1:    rd_msb = rd_shift[15];
         2'd2:    rd_msb = rd_shift[31];
         default: rd_msb = rd_shift[DW-1];
      endcase
   end

   assign rd_fill = sext_q & rd_msb;

   generate
      for (genvar gi = 0; gi < DW; gi++) begin : g_ext
         assign rd_ext[gi] = (4'(gi / 8) < rd_bytes) ? rd_shift[gi] : rd_fill;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      aw_valid_d  = aw_valid_q;
      b_ready_d   = b_ready_q;
      ar_valid_d  = ar_valid_q;
      r_ready_d   = r_ready_q;
      rsp_valid_d = 1'b0;          // completion is a single-cycle pulse
      rsp_err_d   = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      strb_d      = strb_q;
      size_d      = size_q;
      sext_d      = sext_q;
      off_d       = off_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d  = req_base;
               wdata_d = req_wshift;
               strb_d  = req_strb;
               size_d  = req_size;
               sext_d  = req_sext;
               off_d   = req_off;
               if (req_illegal) begin
                  state_d = S_ERR;
               end else if (req_wr) begin
                  state_d    = S_W_ADDR;
                  aw_valid_d = 1'b1;
               end else begin
                  state_d    = S_R_ADDR;
                  ar_valid_d = 1'b1;
               end
            end
         end

         S_W_ADDR: begin
            if (aw_ready) begin
               aw_valid_d = 1'b0;
               b_ready_d  = 1'b1;
               state_d    = S_W_RESP;
            end
         end

         S_W_RESP: begin
            if (b_valid && b_ready_q) begin
               b_ready_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = b_err;
               state_d     = S_IDLE;
            end
         end

         S_R_ADDR: begin
            if (ar_ready) begin
               ar_valid_d = 1'b0;
               r_ready_d  = 1'b1;
               state_d    = S_R_DATA;
            end
         end

         S_R_DATA: begin
            if (r_valid && r_ready_q) begin
               r_ready_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = r_err;
               rsp_rdata_d = r_err ? '0 : rd_ext;
               state_d     = S_IDLE;
            end
         end

         S_ERR: begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         aw_valid_q  <= 1'b0;
         b_ready_q   <= 1'b0;
         ar_valid_q  <= 1'b0;
         r_ready_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         strb_q      <= '0;
         size_q      <= '0;
         sext_q      <= 1'b0;
         off_q       <= '0;
      end else begin
         state_q     <= state_d;
         aw_valid_q  <= aw_valid_d;
         b_ready_q   <= b_ready_d;
         ar_valid_q  <= ar_valid_d;
         r_ready_q   <= r_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         strb_q      <= strb_d;
         size_q      <= size_d;
         sext_q      <= sext_d;
         off_q       <= off_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign aw_valid  = aw_valid_q;
   assign aw_addr   = addr_q;
   assign w_data    = wdata_q;
   assign w_strb    = strb_q;
   assign b_ready   = b_ready_q;
   assign ar_valid  = ar_valid_q;
   assign ar_addr   = addr_q;
   assign ar_size   = {1'b0, size_q};
   assign r_ready   = r_ready_q;

endmodule

// File: tb/tb_ysyx_22041207_lsu.sv
`timescale 1ns/1ps
module tb_ysyx_22041207_lsu;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // ---------------- DW=64 instance signals ----------------
   logic        req_valid, req_ready, req_wr, req_sext, busy;
   logic [63:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        rsp_valid, rsp_err;
   logic [63:0] rsp_rdata;
   logic        aw_valid, aw_ready, b_valid, b_ready, b_err;
   logic [63:0] aw_addr, w_data;
   logic [7:0]  w_strb;
   logic        ar_valid, ar_ready, r_valid, r_ready, r_err;
   logic [63:0] ar_addr, r_data;
   logic [2:0]  ar_size;

   // ---------------- DW=32 instance signals ----------------
   logic        req_valid32, req_ready32, busy32, rsp_valid32, rsp_err32;
   logic [31:0] req_wdata32, rsp_rdata32, w_data32, r_data32;
   logic        aw_valid32, aw_ready32, b_valid32, b_ready32;
   logic        ar_valid32, ar_ready32, r_valid32, r_ready32;
   logic [63:0] aw_addr32, ar_addr32;
   logic [3:0]  w_strb32;
   logic [2:0]  ar_size32;

   ysyx_22041207_lsu #(.AW(64), .DW(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_size(req_size), .req_sext(req_sext),
      .req_wdata(req_wdata), .busy(busy),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
      .w_data(w_data), .w_strb(w_strb),
      .b_valid(b_valid), .b_ready(b_ready), .b_err(b_err),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_size(ar_size),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_err(r_err)
   );

   // Always-ready slave for the 32-bit instance
   assign aw_ready32 = 1'b1;
   assign ar_ready32 = 1'b1;
   assign b_valid32  = b_ready32;
   assign r_valid32  = r_ready32;
   assign r_data32   = 32'h8000_1234;

   ysyx_22041207_lsu #(.AW(64), .DW(32)) dut32 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid32), .req_ready(req_ready32), .req_wr(req_wr),
      .req_addr(req_addr), .req_size(req_size), .req_sext(req_sext),
      .req_wdata(req_wdata32), .busy(busy32),
      .rsp_valid(rsp_valid32), .rsp_rdata(rsp_rdata32), .rsp_err(rsp_err32),
      .aw_valid(aw_valid32), .aw_ready(aw_ready32), .aw_addr(aw_addr32),
      .w_data(w_data32), .w_strb(w_strb32),
      .b_valid(b_valid32), .b_ready(b_ready32), .b_err(1'b0),
      .ar_valid(ar_valid32), .ar_ready(ar_ready32), .ar_addr(ar_addr32), .ar_size(ar_size32),
      .r_valid(r_valid32), .r_ready(r_ready32), .r_data(r_data32), .r_err(1'b0)
   );

   int checks = 0;
   int errors = 0;
   int txn_no = 0;
   logic [63:0] mdl_rdata = '0;   // value rsp_rdata must hold

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // ---------------- Reference model (plain arithmetic) ----------------
   function automatic logic mdl_illegal(input logic [63:0] addr, input logic [1:0] size, input int nb);
      logic [63:0] nbytes;
      nbytes = 64'd1 << size;
      return ((addr % nbytes) != 64'd0) || (nbytes > 64'(nb));
   endfunction

   function automatic logic [7:0] mdl_strb(input logic [63:0] addr, input logic [1:0] size);
      int off;
      int nbytes;
      logic [15:0] m;
      off    = int'(addr % 64'd8);
      nbytes = 1 << size;
      m      = ((16'd1 << nbytes) - 16'd1) << off;
      return m[7:0];
   endfunction

   function automatic logic [63:0] mdl_load(input logic [63:0] beat, input logic [63:0] addr,
                                            input logic [1:0] size, input logic sext);
      int off;
      int nbits;
      logic [63:0] x;
      logic [63:0] mask;
      off   = int'(addr % 64'd8);
      nbits = 8 * (1 << size);
      x     = beat >> (8 * off);
      mask  = (nbits == 64) ? {64{1'b1}} : ((64'd1 << nbits) - 64'd1);
      x     = x & mask;
      if (sext && x[nbits-1]) x = x | ~mask;
      return x;
   endfunction

   task automatic chk_reset_state();
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_err",   64'(rsp_err),   64'd0);
      chk("rst_rsp_rdata", rsp_rdata,      64'd0);
      chk("rst_aw_valid",  64'(aw_valid),  64'd0);
      chk("rst_ar_valid",  64'(ar_valid),  64'd0);
      chk("rst_b_ready",   64'(b_ready),   64'd0);
      chk("rst_r_ready",   64'(r_ready),   64'd0);
      chk("rst_aw_addr",   aw_addr,        64'd0);
      chk("rst_w_data",    w_data,         64'd0);
      chk("rst_w_strb",    64'(w_strb),    64'd0);
      chk("rst_ar_size",   64'(ar_size),   64'd0);
   endtask

   // Issue one request to the 64-bit unit (called at a negedge with the unit
   // idle), act as a slave with the given handshake delays, and check every
   // observed cycle against the model. Returns at the rsp_valid negedge.
   task automatic run_txn(input logic wr, input logic [63:0] addr, input logic [1:0] size,
                          input logic sext, input logic [63:0] wdata, input logic [63:0] beat,
                          input logic berr, input int a_dly, input int d_dly,
                          output logic o_err, output logic [63:0] o_rdata,
                          output logic [7:0] o_strb, output logic [63:0] o_wdata, output int o_lat);
      logic ill;
      int   a_cnt;
      int   d_cnt;
      int   lat;
      bit   saw_bus;
      logic [63:0] base;
      ill     = mdl_illegal(addr, size, 8);
      base    = addr & ~64'h7;
      a_cnt   = 0;
      d_cnt   = 0;
      lat     = 0;
      saw_bus = 0;
      o_err   = 1'b0;
      o_rdata = '0;
      o_strb  = '0;
      o_wdata = '0;
      chk("req_ready_at_issue", 64'(req_ready), 64'd1);
      req_wr = wr; req_addr = addr; req_size = size; req_sext = sext; req_wdata = wdata;
      req_valid = 1'b1;
      for (int cyc = 1; cyc <= 60 && lat == 0; cyc++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (cyc == 1) chk("rsp_pulse_width", 64'(rsp_valid), 64'd0);
         if (aw_valid || ar_valid) saw_bus = 1;
         if (aw_valid) begin
            chk("aw_addr", aw_addr, base);
            chk("w_data",  w_data,  wdata << (8 * (addr % 64'd8)));
            chk("w_strb",  64'(w_strb), 64'(mdl_strb(addr, size)));
            o_strb  = w_strb;
            o_wdata = w_data;
         end
         if (ar_valid) begin
            chk("ar_addr", ar_addr, base);
            chk("ar_size", 64'(ar_size), 64'(size));
         end
         if (rsp_valid) begin
            lat     = cyc;
            o_err   = rsp_err;
            o_rdata = rsp_rdata;
            chk("busy_done", 64'(busy), 64'd0);
         end else begin
            chk("busy_active", 64'(busy), 64'd1);
         end
         // slave responses for the next rising edge
         aw_ready = aw_valid && (a_cnt >= a_dly);
         ar_ready = ar_valid && (a_cnt >= a_dly);
         if (aw_valid || ar_valid) a_cnt++;
         b_valid = b_ready && (d_cnt >= d_dly);
         r_valid = r_ready && (d_cnt >= d_dly);
         if (b_ready || r_ready) d_cnt++;
         b_err  = berr;
         r_err  = berr;
         r_data = beat;
      end
      aw_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0; b_err = 0; r_err = 0;
      if (lat == 0) chk("rsp_timeout", 64'd0, 64'd1);
      if (!wr && !ill) mdl_rdata = berr ? 64'd0 : mdl_load(beat, addr, size, sext);
      chk("latency", 64'(lat), ill ? 64'd2 : 64'(3 + a_dly + d_dly));
      chk("rsp_err", 64'(o_err), 64'(ill || berr));
      chk("rsp_rdata", o_rdata, mdl_rdata);
      chk("bus_traffic", 64'(saw_bus), 64'(!ill));
      o_lat = lat;
      txn_no++;
      $display("txn %0d wr=%0d addr=%h size=%0d sext=%0d err=%0d rdata=%h lat=%0d",
               txn_no, wr, addr, size, sext, o_err, o_rdata, lat);
   endtask

   task automatic run32(input logic wr, input logic [63:0] addr, input logic [1:0] size,
                        input logic sext, input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_rdata, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata, input int exp_lat, input logic exp_bus);
      int lat;
      bit saw;
      logic [3:0]  strb;
      logic [31:0] wd;
      lat = 0; saw = 0; strb = '0; wd = '0;
      req_wr = wr; req_addr = addr; req_size = size; req_sext = sext; req_wdata32 = wdata;
      req_valid32 = 1'b1;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         @(negedge clk);
         req_valid32 = 1'b0;
         if (aw_valid32 || ar_valid32) saw = 1;
         if (aw_valid32) begin strb = w_strb32; wd = w_data32; end
         if (rsp_valid32) begin
            lat = c;
            chk("dw32_err", 64'(rsp_err32), 64'(exp_err));
            if (!wr) chk("dw32_rdata", 64'(rsp_rdata32), 64'(exp_rdata));
         end
      end
      chk("dw32_latency", 64'(lat), 64'(exp_lat));
      chk("dw32_bus", 64'(saw), 64'(exp_bus));
      chk("dw32_strb", 64'(strb), 64'(exp_strb));
      chk("dw32_wdata", 64'(wd), 64'(exp_wdata));
      txn_no++;
      $display("txn %0d dw32 wr=%0d addr=%h size=%0d lat=%0d", txn_no, wr, addr, size, lat);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
         chk("idle_rdata_hold", rsp_rdata, mdl_rdata);
      end
   endtask

   typedef struct {
      logic        wr;
      logic [63:0] addr;
      logic [1:0]  size;
      logic        sext;
      logic [63:0] wdata;
      logic [63:0] beat;
      logic        berr;
      logic        exp_err;
      logic [63:0] exp_rdata;
      logic [7:0]  exp_strb;
      logic [63:0] exp_wdata;
      int          exp_lat;
   } vec_t;

   vec_t vt[13];

   logic        o_err;
   logic [63:0] o_rdata, o_wdata;
   logic [7:0]  o_strb;
   int          o_lat;
   bit          got;

   initial begin
      vt[0]  = '{1'b1, 64'h8000_0006, 2'd1, 1'b0, 64'hBEEF, 64'h0, 1'b0,
                 1'b0, 64'h0, 8'hC0, 64'hBEEF_0000_0000_0000, 3};
      vt[1]  = '{1'b0, 64'h8000_0003, 2'd0, 1'b1, 64'h0, 64'h0000_0000_8000_0000, 1'b0,
                 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0, 3};
      vt[2]  = '{1'b0, 64'h8000_0003, 2'd0, 1'b0, 64'h0, 64'h0000_0000_8000_0000, 1'b0,
                 1'b0, 64'h80, 8'h00, 64'h0, 3};
      vt[3]  = '{1'b0, 64'h8000_0006, 2'd2, 1'b0, 64'h0, 64'h0, 1'b0,
                 1'b1, 64'h80, 8'h00, 64'h0, 2};
      vt[4]  = '{1'b0, 64'h8000_0008, 2'd3, 1'b0, 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b1,
                 1'b1, 64'h0, 8'h00, 64'h0, 3};
      vt[5]  = '{1'b0, 64'h8000_0010, 2'd3, 1'b1, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0,
                 1'b0, 64'h0123_4567_89AB_CDEF, 8'h00, 64'h0, 3};
      vt[6]  = '{1'b0, 64'h8000_000E, 2'd1, 1'b1, 64'h0, 64'h8001_0000_0000_0000, 1'b0,
                 1'b0, 64'hFFFF_FFFF_FFFF_8001, 8'h00, 64'h0, 3};
      vt[7]  = '{1'b1, 64'h8000_0008, 2'd3, 1'b0, 64'h1122_3344_5566_7788, 64'h0, 1'b0,
                 1'b0, 64'hFFFF_FFFF_FFFF_8001, 8'hFF, 64'h1122_3344_5566_7788, 3};
      vt[8]  = '{1'b1, 64'h8000_0005, 2'd2, 1'b0, 64'h1234, 64'h0, 1'b0,
                 1'b1, 64'hFFFF_FFFF_FFFF_8001, 8'h00, 64'h0, 2};
      vt[9]  = '{1'b1, 64'h8000_0007, 2'd0, 1'b0, 64'hAB, 64'h0, 1'b0,
                 1'b0, 64'hFFFF_FFFF_FFFF_8001, 8'h80, 64'hAB00_0000_0000_0000, 3};
      vt[10] = '{1'b1, 64'h8000_0004, 2'd2, 1'b0, 64'hDEAD_BEEF, 64'h0, 1'b1,
                 1'b1, 64'hFFFF_FFFF_FFFF_8001, 8'hF0, 64'hDEAD_BEEF_0000_0000, 3};
      vt[11] = '{1'b0, 64'h8000_0004, 2'd2, 1'b0, 64'h0, 64'h8765_4321_0000_0000, 1'b0,
                 1'b0, 64'h8765_4321, 8'h00, 64'h0, 3};
      vt[12] = '{1'b0, 64'h8000_0004, 2'd2, 1'b1, 64'h0, 64'h8765_4321_0000_0000, 1'b0,
                 1'b0, 64'hFFFF_FFFF_8765_4321, 8'h00, 64'h0, 3};

      rst_n = 1'b0;
      req_valid = 0; req_wr = 0; req_addr = '0; req_size = '0; req_sext = 0; req_wdata = '0;
      aw_ready = 0; b_valid = 0; b_err = 0; ar_ready = 0; r_valid = 0; r_err = 0; r_data = '0;
      req_valid32 = 0; req_wdata32 = '0;

      repeat (3) @(negedge clk);
      chk_reset_state();
      rst_n = 1'b1;
      idle_cycles(2);

      // ---------- directed vectors ----------
      for (int i = 0; i < 13; i++) begin
         run_txn(vt[i].wr, vt[i].addr, vt[i].size, vt[i].sext, vt[i].wdata, vt[i].beat,
                 vt[i].berr, 0, 0, o_err, o_rdata, o_strb, o_wdata, o_lat);
         chk("vec_err",   64'(o_err),   64'(vt[i].exp_err));
         chk("vec_rdata", o_rdata,      vt[i].exp_rdata);
         chk("vec_strb",  64'(o_strb),  64'(vt[i].exp_strb));
         chk("vec_wdata", o_wdata,      vt[i].exp_wdata);
         chk("vec_lat",   64'(o_lat),   64'(vt[i].exp_lat));
      end

      // ---------- slow store, then a load accepted in the rsp_valid cycle ----------
      run_txn(1'b1, 64'h8000_0022, 2'd1, 1'b0, 64'h5A5A, 64'h0, 1'b0, 5, 5,
              o_err, o_rdata, o_strb, o_wdata, o_lat);
      chk("slow_store_lat", 64'(o_lat), 64'd13);
      run_txn(1'b0, 64'h8000_0021, 2'd0, 1'b1, 64'h0, 64'h0000_0000_0000_7F00, 1'b0, 0, 0,
              o_err, o_rdata, o_strb, o_wdata, o_lat);
      chk("b2b_load_rdata", o_rdata, 64'h7F);
      idle_cycles(1);

      // ---------- DW=32 instance ----------
      run32(1'b0, 64'h8000_0000, 2'd3, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 2, 1'b0);
      run32(1'b0, 64'h8000_0002, 2'd1, 1'b1, 32'h0, 1'b0, 32'hFFFF_8000, 4'h0, 32'h0, 3, 1'b1);
      run32(1'b1, 64'h8000_0003, 2'd0, 1'b0, 32'h5A, 1'b0, 32'h0, 4'h8, 32'h5A00_0000, 3, 1'b1);
      run32(1'b1, 64'h8000_0000, 2'd3, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 2, 1'b0);

      // ---------- randomized traffic ----------
      for (int n = 0; n < 150; n++) begin
         logic        r_wr, r_sext, r_berr;
         logic [1:0]  r_size;
         logic [63:0] r_addr, r_wd, r_beat;
         r_wr   = 1'($urandom_range(0, 1));
         r_sext = 1'($urandom_range(0, 1));
         r_size = 2'($urandom_range(0, 3));
         r_addr = {32'h8000_0000, $urandom()};
         if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~((64'd1 << r_size) - 64'd1);
         r_wd   = {$urandom(), $urandom()};
         r_beat = {$urandom(), $urandom()};
         r_berr = ($urandom_range(0, 7) == 0);
         run_txn(r_wr, r_addr, r_size, r_sext, r_wd, r_beat, r_berr,
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 o_err, o_rdata, o_strb, o_wdata, o_lat);
         idle_cycles($urandom_range(0, 2));
      end

      // ---------- reset while waiting for read data ----------
      run_txn(1'b0, 64'h8000_0040, 2'd3, 1'b0, 64'h0, 64'hCAFE_F00D_1234_5678, 1'b0, 0, 0,
              o_err, o_rdata, o_strb, o_wdata, o_lat);
      req_wr = 0; req_addr = 64'h8000_0048; req_size = 2'd2; req_sext = 0;
      req_valid = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         ar_ready  = ar_valid;
         if (r_ready) got = 1;
      end
      ar_ready = 1'b0;
      chk("reach_r_data", 64'(got), 64'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_state();
      mdl_rdata = '0;
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycles(1);
      run_txn(1'b0, 64'h8000_0044, 2'd2, 1'b1, 64'h0, 64'hF000_0001_0000_0000, 1'b0, 1, 2,
              o_err, o_rdata, o_strb, o_wdata, o_lat);
      chk("post_reset_load", o_rdata, 64'hFFFF_FFFF_F000_0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
